// File: rtl/alu_datapath_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_datapath_if
// Brief    : Control word, operands and result bundle between FSM and datapath.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_datapath_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [1:0]       s1_mux;
    logic [1:0]       wa;
    logic             we;
    logic [1:0]       raa;
    logic             rea;
    logic [1:0]       rab;
    logic             reb;
    logic [1:0]       c;
    logic             s2_mux;
    logic             Done;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             zero_flag;
    logic             carry_flag;

    modport master (
        output in1, in2, s1_mux, wa, we, raa, rea, rab, reb, c, s2_mux, Done,
        input  out_data, out_valid, zero_flag, carry_flag
    );

    modport slave (
        input  in1, in2, s1_mux, wa, we, raa, rea, rab, reb, c, s2_mux, Done,
        output out_data, out_valid, zero_flag, carry_flag
    );
endinterface
`default_nettype wire

// File: rtl/alu_datapath.sv
`default_nettype none
// ============================================================================
// Module   : alu_datapath
// Brief    : 4-entry register file, 4-function ALU with flags, registered output.
// Revision : 1.0 - initial release
// ============================================================================
module alu_datapath #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    alu_datapath_if.slave bus
);

    logic [WIDTH-1:0] rf_q [4];
    logic [WIDTH-1:0] rf_d [4];
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             zero_flag_q, zero_flag_d;
    logic             carry_flag_q, carry_flag_d;

    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] wr_data;
    logic             wr_en;

    // Entry 0 never receives a write, so it reads as zero forever.
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        if (bus.rea) rd_a = rf_q[bus.raa];
        if (bus.reb) rd_b = rf_q[bus.rab];
    end

    // Subtraction borrow falls out of the extended MSB when A < B.
    always_comb begin
        sum_ext   = '0;
        alu_res   = '0;
        alu_carry = 1'b0;
        case (bus.c)
            2'b11: begin
                sum_ext   = {1'b0, rd_a} + {1'b0, rd_b};
                alu_res   = sum_ext[WIDTH-1:0];
                alu_carry = sum_ext[WIDTH];
            end
            2'b10: begin
                sum_ext   = {1'b0, rd_a} - {1'b0, rd_b};
                alu_res   = sum_ext[WIDTH-1:0];
                alu_carry = sum_ext[WIDTH];
            end
            2'b01:   alu_res = rd_a & rd_b;
            default: alu_res = rd_a ^ rd_b;
        endcase
    end

    always_comb begin
        case (bus.s1_mux)
            2'b11:   wr_data = bus.in1;
            2'b10:   wr_data = bus.in2;
            2'b01:   wr_data = '0;
            default: wr_data = alu_res;
        endcase
    end

    assign wr_en = bus.we && (bus.wa != 2'b00);

    always_comb begin
        rf_d         = rf_q;
        out_data_d   = out_data_q;
        zero_flag_d  = zero_flag_q;
        carry_flag_d = carry_flag_q;
        out_valid_d  = bus.Done;
        if (wr_en) begin
            rf_d[bus.wa] = wr_data;
            if (bus.s1_mux == 2'b00) begin
                zero_flag_d  = (alu_res == '0);
                carry_flag_d = alu_carry;
            end
        end
        rf_d[0] = '0;
        if (bus.s2_mux) out_data_d = alu_res;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_q         <= '{default: '0};
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            zero_flag_q  <= 1'b0;
            carry_flag_q <= 1'b0;
        end else begin
            rf_q         <= rf_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            zero_flag_q  <= zero_flag_d;
            carry_flag_q <= carry_flag_d;
        end
    end

    assign bus.out_data   = out_data_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.zero_flag  = zero_flag_q;
    assign bus.carry_flag = carry_flag_q;

endmodule
`default_nettype wire
